// File: rtl/fft_corr_pkg.sv
// Shared types and helpers for the IFFT shift controller.
// Holds the shift width, FSM state encoding and the bound clamp.
package fft_corr_pkg;

  localparam int SHIFT_W = 4;

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_RUN,
    SC_UPDATE
  } shift_ctrl_state_t;

  function automatic logic [SHIFT_W-1:0] clamp_shift(
    input logic [SHIFT_W-1:0] v,
    input int                 lo,
    input int                 hi
  );
    if (int'(v) < lo) return SHIFT_W'(lo);
    if (int'(v) > hi) return SHIFT_W'(hi);
    return v;
  endfunction

endpackage

// File: rtl/ifft_shift_ctrl_if.sv
// Monitor/drive bundle between the multiply-shift stage and the
// shift controller; master is the stage side, slave the controller.
interface ifft_shift_ctrl_if;
  import fft_corr_pkg::*;

  logic               mon_tvalid;
  logic               mon_overflow;
  logic [SHIFT_W-1:0] ifft_shift;
  logic               shift_update;
  logic               frame_done;
  logic               frame_ovf;

  modport master (
    output mon_tvalid, mon_overflow,
    input  ifft_shift, shift_update, frame_done, frame_ovf
  );

  modport slave (
    input  mon_tvalid, mon_overflow,
    output ifft_shift, shift_update, frame_done, frame_ovf
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
// Used for the clean-frame run length and the frame statistics.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // clear wins over increment; hold once saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != {W{1'b1}}) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ifft_shift_ctrl.sv
// Frame-level adaptive IFFT shift controller.
// Optional statistics outputs: define SHIFT_CTRL_STATS_EN.
module ifft_shift_ctrl
  import fft_corr_pkg::*;
#(
  parameter int FRAME_LEN    = 1024,
  parameter int MAX_SHIFT    = 15,
  parameter int MIN_SHIFT    = 0,
  parameter int CLEAN_FRAMES = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               cfg_enable,
  input  logic [SHIFT_W-1:0] cfg_init_shift,
  ifft_shift_ctrl_if.slave   mon
`ifdef SHIFT_CTRL_STATS_EN
  ,
  output logic [31:0]        stat_frames,
  output logic [31:0]        stat_ovf_frames
`endif
);

  localparam int CW  = $clog2(FRAME_LEN);
  localparam int CLW = $clog2(CLEAN_FRAMES + 1);
  localparam logic [CW-1:0]      LAST  = CW'(FRAME_LEN - 1);
  localparam logic [CLW-1:0]     CLAST = CLW'(CLEAN_FRAMES - 1);
  localparam logic [SHIFT_W-1:0] MIN_S = SHIFT_W'(MIN_SHIFT);
  localparam logic [SHIFT_W-1:0] MAX_S = SHIFT_W'(MAX_SHIFT);

  shift_ctrl_state_t  state_q, state_n;
  logic [CW-1:0]      beat_q, beat_n;
  logic               acc_q, acc_n;
  logic [SHIFT_W-1:0] shift_q, shift_n;
  logic               upd_q, upd_n;
  logic               done_q, done_n;
  logic               fovf_q, fovf_n;
  logic [CLW-1:0]     clean;
  logic               clean_inc, clean_clr;

  sat_counter #(.W(CLW)) u_clean (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (clean_inc),
    .clr   (clean_clr),
    .cnt   (clean)
  );

  // state and registered outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= SC_IDLE;
      beat_q  <= '0;
      acc_q   <= 1'b0;
      shift_q <= MIN_S;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      fovf_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      beat_q  <= beat_n;
      acc_q   <= acc_n;
      shift_q <= shift_n;
      upd_q   <= upd_n;
      done_q  <= done_n;
      fovf_q  <= fovf_n;
    end
  end

  // frame counting, shift decision and next state
  always_comb begin
    state_n   = state_q;
    beat_n    = beat_q;
    acc_n     = acc_q;
    shift_n   = shift_q;
    upd_n     = 1'b0;
    done_n    = 1'b0;
    fovf_n    = 1'b0;
    clean_inc = 1'b0;
    clean_clr = 1'b0;
    unique case (state_q)
      SC_IDLE: begin
        shift_n   = clamp_shift(cfg_init_shift, MIN_SHIFT, MAX_SHIFT);
        beat_n    = '0;
        acc_n     = 1'b0;
        clean_clr = 1'b1;
        state_n   = SC_RUN;
      end
      SC_RUN: begin
        if (mon.mon_tvalid) begin
          beat_n = beat_q + CW'(1);
          acc_n  = acc_q | mon.mon_overflow;
          if (beat_q == LAST) begin
            beat_n  = '0;
            state_n = SC_UPDATE;
            done_n  = 1'b1;
            fovf_n  = acc_n;
          end
        end
      end
      SC_UPDATE: begin
        beat_n = mon.mon_tvalid ? CW'(1) : '0;
        acc_n  = mon.mon_tvalid & mon.mon_overflow;
        if (acc_q) begin
          if (shift_q > MIN_S) shift_n = shift_q - SHIFT_W'(1);
          clean_clr = 1'b1;
        end else if (clean == CLAST) begin
          if (shift_q < MAX_S) shift_n = shift_q + SHIFT_W'(1);
          clean_clr = 1'b1;
        end else begin
          clean_inc = 1'b1;
        end
        upd_n   = (shift_n != shift_q);
        state_n = SC_RUN;
      end
      default: state_n = SC_IDLE;
    endcase
    // disable drops any partial frame and parks at the init shift
    if (!cfg_enable) begin
      state_n   = SC_IDLE;
      beat_n    = '0;
      acc_n     = 1'b0;
      shift_n   = clamp_shift(cfg_init_shift, MIN_SHIFT, MAX_SHIFT);
      upd_n     = 1'b0;
      done_n    = 1'b0;
      fovf_n    = 1'b0;
      clean_inc = 1'b0;
      clean_clr = 1'b1;
    end
  end

  assign mon.ifft_shift   = shift_q;
  assign mon.shift_update = upd_q;
  assign mon.frame_done   = done_q;
  assign mon.frame_ovf    = fovf_q;

`ifdef SHIFT_CTRL_STATS_EN
  sat_counter #(.W(32)) u_frames (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (done_q),
    .clr   (1'b0),
    .cnt   (stat_frames)
  );

  sat_counter #(.W(32)) u_ovf_frames (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (done_q & fovf_q),
    .clr   (1'b0),
    .cnt   (stat_ovf_frames)
  );
`endif

endmodule

// File: tb/tb_ifft_shift_ctrl.sv
// Bench for ifft_shift_ctrl: directed frame scenarios then random
// traffic, every cycle compared against a frame-level model.
module tb_ifft_shift_ctrl;
  import fft_corr_pkg::*;

  localparam int FL   = 8;
  localparam int CF   = 4;
  localparam int MINS = 0;
  localparam int MAXS = 15;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       cfg_enable;
  logic [3:0] cfg_init_shift;

  ifft_shift_ctrl_if bus();

`ifdef SHIFT_CTRL_STATS_EN
  logic [31:0] stat_frames, stat_ovf_frames;
`endif

  ifft_shift_ctrl #(
    .FRAME_LEN    (FL),
    .MAX_SHIFT    (MAXS),
    .MIN_SHIFT    (MINS),
    .CLEAN_FRAMES (CF)
  ) dut (
    .aclk           (clk),
    .aresetn        (aresetn),
    .cfg_enable     (cfg_enable),
    .cfg_init_shift (cfg_init_shift),
    .mon            (bus.slave)
`ifdef SHIFT_CTRL_STATS_EN
    ,
    .stat_frames     (stat_frames),
    .stat_ovf_frames (stat_ovf_frames)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_upd  = 0;

  // frame-level reference: samples seen in the open frame,
  // whether it is dirty, and a frame waiting to be judged
  int  m_shift, m_clean, m_seen;
  bit  m_dirty, m_active, m_judge, m_judge_dirty;
  bit  m_done, m_fovf, m_upd;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic int clampi(input int v);
    return v < MINS ? MINS : (v > MAXS ? MAXS : v);
  endfunction

  task automatic model_reset();
    m_shift = MINS; m_clean = 0; m_seen = 0;
    m_dirty = 0; m_active = 0; m_judge = 0; m_judge_dirty = 0;
    m_done = 0; m_fovf = 0; m_upd = 0;
  endtask

  task automatic model_edge();
    bit v, o;
    int nxt;
    v = bus.mon_tvalid;
    o = bus.mon_overflow;
    m_done = 0; m_fovf = 0; m_upd = 0;
    if (!aresetn) begin
      model_reset();
    end else if (!cfg_enable || !m_active) begin
      m_shift = clampi(int'(cfg_init_shift));
      m_clean = 0; m_seen = 0; m_dirty = 0; m_judge = 0;
      m_active = cfg_enable;
    end else if (m_judge) begin
      nxt = m_shift;
      if (m_judge_dirty) begin
        nxt = m_shift > MINS ? m_shift - 1 : m_shift;
        m_clean = 0;
      end else begin
        m_clean++;
        if (m_clean == CF) begin
          nxt = m_shift < MAXS ? m_shift + 1 : m_shift;
          m_clean = 0;
        end
      end
      m_upd   = (nxt != m_shift);
      m_shift = nxt;
      m_judge = 0;
      m_seen  = v ? 1 : 0;
      m_dirty = v & o;
    end else if (v) begin
      m_seen++;
      m_dirty |= o;
      if (m_seen == FL) begin
        m_done = 1; m_fovf = m_dirty;
        m_judge = 1; m_judge_dirty = m_dirty;
        m_seen = 0; m_dirty = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("ifft_shift", 32'(bus.ifft_shift), 32'(m_shift));
    check("frame_done", 32'(bus.frame_done), 32'(m_done));
    check("frame_ovf", 32'(bus.frame_ovf), 32'(m_fovf));
    check("shift_update", 32'(bus.shift_update), 32'(m_upd));
    if (bus.frame_done) n_done++;
    if (bus.shift_update) n_upd++;
  endtask

  // one clock: drive at negedge, model at posedge, compare at negedge
  task automatic step(input bit v, input bit o);
    bus.mon_tvalid   = v;
    bus.mon_overflow = o;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // full frame with overflow on beat ob (-1: clean), plus the
  // judging cycle so the new shift is visible afterwards
  task automatic frame(input int ob);
    for (int i = 0; i < FL; i++) step(1'b1, i == ob);
    step(1'b0, 1'b0);
  endtask

  task automatic restart(input logic [3:0] init);
    cfg_enable = 1'b0;
    cfg_init_shift = init;
    step(1'b0, 1'b0);
    cfg_enable = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    aresetn = 1'b0;
    cfg_enable = 1'b0;
    cfg_init_shift = 4'd6;
    bus.mon_tvalid = 1'b0;
    bus.mon_overflow = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    aresetn = 1'b1;
    step(1'b0, 1'b0);
    check("t1_init_shift", 32'(bus.ifft_shift), 32'd6);

    // T1 mid-frame reset is immediate
    cfg_enable = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    #2 aresetn = 1'b0;
    #1;
    model_reset();
    check("t1_rst_shift", 32'(bus.ifft_shift), 32'(MINS));
    check("t1_rst_pulses",
          32'({bus.frame_done, bus.frame_ovf, bus.shift_update}), 32'd0);
    @(negedge clk);
    cfg_enable = 1'b0;
    aresetn = 1'b1;
    step(1'b0, 1'b0);
    check("t1_release", 32'(bus.ifft_shift), 32'd6);

    // T2 overflow frame lowers the shift
    cfg_enable = 1'b1;
    step(1'b0, 1'b0);
    n_upd = 0;
    frame(3);
    check("t2_shift", 32'(bus.ifft_shift), 32'd5);
    check("t2_upd_cnt", 32'(n_upd), 32'd1);

    // T3 four clean frames raise it once
    n_done = 0; n_upd = 0;
    for (int f = 0; f < CF; f++) begin
      frame(-1);
      if (f < CF - 1) check("t3_hold", 32'(bus.ifft_shift), 32'd5);
    end
    check("t3_shift", 32'(bus.ifft_shift), 32'd6);
    check("t3_done_cnt", 32'(n_done), 32'(CF));
    check("t3_upd_cnt", 32'(n_upd), 32'd1);

    // T4 bounds hold without a pulse
    restart(4'd0);
    n_upd = 0;
    frame(5);
    check("t4_min", 32'(bus.ifft_shift), 32'd0);
    restart(4'd15);
    for (int f = 0; f < CF; f++) frame(-1);
    check("t4_max", 32'(bus.ifft_shift), 32'd15);
    check("t4_upd_cnt", 32'(n_upd), 32'd0);

    // T5 last-beat overflow and overflow during judging cycle
    restart(4'd6);
    for (int i = 0; i < FL; i++) step(1'b1, i == FL - 1);
    check("t5_last_ovf", 32'(bus.frame_ovf), 32'd1);
    step(1'b1, 1'b1);
    for (int i = 1; i < FL; i++) step(1'b1, 1'b0);
    check("t5_next_done", 32'(bus.frame_done), 32'd1);
    check("t5_next_ovf", 32'(bus.frame_ovf), 32'd1);
    step(1'b0, 1'b0);
    check("t5_shift", 32'(bus.ifft_shift), 32'd4);

    // T6 disable mid-frame discards it
    n_done = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    cfg_enable = 1'b0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("t6_no_done", 32'(n_done), 32'd0);
    cfg_enable = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < FL - 1; i++) step(1'b1, 1'b0);
    check("t6_seven", 32'(n_done), 32'd0);
    step(1'b1, 1'b0);
    check("t6_eight", 32'(n_done), 32'd1);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 79) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 15) == 0) cfg_init_shift = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
